// File: rtl/flash_loader_pkg.sv
// Shared types for the boot loader: FSM state encoding and the default frame marker.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/flash_loader_packer.sv
// Little-endian byte-to-word packer: byte_idx selects the lane written on each load.
// word_o is the word including the byte being loaded this cycle.
module byte_packer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [7:0]       byte_i,
  output logic             word_full_o,
  output logic [WIDTH-1:0] word_o
);

  localparam int BPW = WIDTH / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0]    byte_idx_q, byte_idx_d;
  logic [WIDTH-1:0] lanes_q, lanes_d;

  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    assign lanes_d[gi*8 +: 8] = (load_i && byte_idx_q == IW'(gi)) ? byte_i : lanes_q[gi*8 +: 8];
  end

  assign word_full_o = (byte_idx_q == IW'(BPW - 1));
  assign word_o      = lanes_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    if (clear_i) begin
      byte_idx_d = '0;
    end else if (load_i) begin
      byte_idx_d = word_full_o ? '0 : byte_idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_idx_q <= '0;
      lanes_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
    end
  end

endmodule

// File: rtl/flash_loader.sv
// Boot loader: parses SYNC/LEN framed byte stream, packs words and strobes them into the
// memory flash port at consecutive addresses. All outputs are registered.
module flash_loader
  import loader_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0,
  parameter int               MAX_WORDS = 2048,
  parameter logic [7:0]       SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BPW = WIDTH / 8;

  loader_state_t    state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      word_idx_q, word_idx_d;
  logic             rx_ready_q, rx_ready_d;
  logic             flash_en_q, flash_en_d;
  logic [WIDTH-1:0] flash_addr_q, flash_addr_d;
  logic [WIDTH-1:0] flash_data_q, flash_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic [15:0]      len_full;
  logic             pk_load, pk_clear, pk_full;
  logic [WIDTH-1:0] pk_word;

  assign accept   = rx_valid && rx_ready_q;
  assign len_full = {rx_data, len_q[7:0]};

  byte_packer #(.WIDTH(WIDTH)) u_packer (
    .clk        (clk),
    .rst_ni     (rst),
    .load_i     (pk_load),
    .clear_i    (pk_clear),
    .byte_i     (rx_data),
    .word_full_o(pk_full),
    .word_o     (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    flash_en_d   = 1'b0;
    flash_addr_d = flash_addr_q;
    flash_data_d = flash_data_q;
    err_d        = err_q;
    pk_load      = 1'b0;
    pk_clear     = 1'b0;
    unique case (state_q)
      IDLE: if (accept && rx_data == SYNC_BYTE) begin
        state_d = LEN_LO;
        err_d   = 1'b0;
      end
      LEN_LO: if (accept) begin
        len_d   = {8'h00, rx_data};
        state_d = LEN_HI;
      end
      LEN_HI: if (accept) begin
        len_d = len_full;
        if (len_full == 16'd0 || len_full > 16'(MAX_WORDS)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          state_d    = DATA;
          word_idx_d = '0;
          pk_clear   = 1'b1;
        end
      end
      DATA: if (accept) begin
        pk_load = 1'b1;
        // Capture the completed word now so the strobe lands one cycle after its last byte.
        if (pk_full) begin
          state_d      = WRITE;
          flash_en_d   = 1'b1;
          flash_addr_d = BASE_ADDR + WIDTH'(BPW) * WIDTH'(word_idx_q);
          flash_data_d = pk_word;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_q == len_q - 16'd1) ? DONE : DATA;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rx_ready_d = (state_d == IDLE) || (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
    busy_d     = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA) || (state_d == WRITE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      rx_ready_q   <= 1'b1;
      flash_en_q   <= 1'b0;
      flash_addr_q <= BASE_ADDR;
      flash_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      rx_ready_q   <= rx_ready_d;
      flash_en_q   <= flash_en_d;
      flash_addr_q <= flash_addr_d;
      flash_data_q <= flash_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign flash_en   = flash_en_q;
  assign flash_addr = flash_addr_q;
  assign flash_data = flash_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader: table of framed streams plus hand sequences for
// error stickiness, rx_valid gaps and reset in the middle of a frame.
module tb_flash_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, flash_en, busy, done, err;
  logic [31:0] flash_addr, flash_data;

  flash_loader dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .flash_en  (flash_en),
    .flash_addr(flash_addr),
    .flash_data(flash_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Byte k of the stream sits at bytes[127-8k -: 8]; word i at wdata[32i +: 32].
  typedef struct packed {
    logic [127:0] bytes;
    logic [31:0]  nb;
    logic [31:0]  n_wr;
    logic [95:0]  wdata;
    logic         exp_err;
    logic [31:0]  exp_done;
  } vec_t;

  vec_t vecs [6];

  int n_vec = 0;
  int n_mis = 0;

  // Monitor, sampled on the falling edge.
  int          cyc = 0, acc_cyc = -10, last_wr = -10;
  int          done_cnt = 0, done_bad = 0, lat_bad = 0, hs_bad = 0;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rx_valid && rx_ready) acc_cyc = cyc;
      if (flash_en) begin
        wr_addr.push_back(flash_addr);
        wr_data.push_back(flash_data);
        if (cyc != acc_cyc + 1) lat_bad++;
        last_wr = cyc;
      end
      if (done) begin
        done_cnt++;
        if (cyc != last_wr + 1) done_bad++;
      end
      if ((busy && !rx_ready) != flash_en) hs_bad++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit accepted = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50 && !accepted; k++) begin
      if (rx_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!accepted) begin
      n_vec++;
      n_mis++;
      $display("FAIL send_timeout: byte 0x%0h not accepted in 50 cycles, expected acceptance", b);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  int base_wr, base_done, base_lat, base_hs, base_db;

  task automatic snap();
    base_wr   = wr_addr.size();
    base_done = done_cnt;
    base_lat  = lat_bad;
    base_hs   = hs_bad;
    base_db   = done_bad;
  endtask

  task automatic check_timing(input string tag);
    check({tag, ".latency"}, 64'(lat_bad - base_lat), 64'd0);
    check({tag, ".ready_vs_write"}, 64'(hs_bad - base_hs), 64'd0);
    check({tag, ".done_timing"}, 64'(done_bad - base_db), 64'd0);
  endtask

  initial begin
    vecs[0] = '{128'hA5_01_00_EF_BE_AD_DE_00_00_00_00_00_00_00_00_00, 7, 1,
                {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 1};
    vecs[1] = '{128'hA5_03_00_00_01_02_03_04_05_06_07_08_09_0A_0B_00, 15, 3,
                {32'h0B0A0908, 32'h07060504, 32'h03020100}, 1'b0, 1};
    vecs[2] = '{128'h00_FF_5A_A5_01_00_11_22_33_44_00_00_00_00_00_00, 10, 1,
                {32'h0, 32'h0, 32'h44332211}, 1'b0, 1};
    vecs[3] = '{128'hA5_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 3, 0,
                96'h0, 1'b1, 0};
    vecs[4] = '{128'hA5_01_08_00_00_00_00_00_00_00_00_00_00_00_00_00, 3, 0,
                96'h0, 1'b1, 0};
    vecs[5] = '{128'hA5_02_00_A5_A5_A5_A5_01_02_03_04_00_00_00_00_00, 11, 2,
                {32'h0, 32'h04030201, 32'hA5A5A5A5}, 1'b0, 1};

    // Reset values
    #1 rst = 1'b0;
    settle(2);
    check("rst.rx_ready", 64'(rx_ready), 64'd1);
    check("rst.flash_en", 64'(flash_en), 64'd0);
    check("rst.flash_addr", 64'(flash_addr), 64'd0);
    check("rst.flash_data", 64'(flash_data), 64'd0);
    check("rst.busy_done_err", 64'({busy, done, err}), 64'd0);
    #2 rst = 1'b1;
    settle(2);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      snap();
      for (int k = 0; k < 32'(vecs[v].nb); k++)
        send_byte(vecs[v].bytes[127 - 8*k -: 8], 0);
      settle(4);
      check({tag, ".writes"}, 64'(wr_addr.size() - base_wr), 64'(vecs[v].n_wr));
      for (int i = 0; i < 32'(vecs[v].n_wr) && base_wr + i < wr_addr.size(); i++) begin
        check($sformatf("%s.addr%0d", tag, i), 64'(wr_addr[base_wr + i]), 64'(4 * i));
        check($sformatf("%s.data%0d", tag, i), 64'(wr_data[base_wr + i]), 64'(vecs[v].wdata[32*i +: 32]));
      end
      if (vecs[v].n_wr != 0)
        check({tag, ".data_hold"}, 64'(flash_data), 64'(vecs[v].wdata[32*(vecs[v].n_wr - 1) +: 32]));
      check({tag, ".err"}, 64'(err), 64'(vecs[v].exp_err));
      check({tag, ".done_pulses"}, 64'(done_cnt - base_done), 64'(vecs[v].exp_done));
      check({tag, ".idle"}, 64'({busy, rx_ready}), 64'b01);
      check_timing(tag);
    end

    // Sticky err: survives discarded bytes, clears on the next accepted SYNC
    snap();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    settle(3);
    check("sticky.err_set", 64'(err), 64'd1);
    send_byte(8'h33, 0);
    settle(1);
    check("sticky.err_after_garbage", 64'(err), 64'd1);
    send_byte(8'hA5, 0);
    check("sticky.err_cleared", 64'({err, busy}), 64'b01);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 0);
    settle(4);
    check("sticky.writes", 64'(wr_addr.size() - base_wr), 64'd1);
    if (wr_addr.size() > base_wr)
      check("sticky.word", {wr_addr[base_wr], wr_data[base_wr]}, {32'h0, 32'h04030201});

    // rx_valid asserted one cycle in three
    snap();
    send_byte(8'hA5, 2); send_byte(8'h02, 2); send_byte(8'h00, 2);
    for (int k = 0; k < 8; k++) send_byte(8'(8'h10 + k), 2);
    settle(4);
    check("gaps.writes", 64'(wr_addr.size() - base_wr), 64'd2);
    if (wr_addr.size() >= base_wr + 2) begin
      check("gaps.word0", {wr_addr[base_wr], wr_data[base_wr]}, {32'h0, 32'h13121110});
      check("gaps.word1", {wr_addr[base_wr+1], wr_data[base_wr+1]}, {32'h4, 32'h17161514});
    end
    check("gaps.done_pulses", 64'(done_cnt - base_done), 64'd1);
    check_timing("gaps");

    // Reset after five data bytes of a two-word frame
    snap();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h20 + k), 0);
    #2 rst = 1'b0;
    #1;
    check("midrst.rx_ready", 64'(rx_ready), 64'd1);
    check("midrst.addr_data", {flash_addr, flash_data}, 64'd0);
    check("midrst.flags", 64'({flash_en, busy, done, err}), 64'd0);
    settle(3);
    #3 rst = 1'b1;
    settle(2);
    check("midrst.writes", 64'(wr_addr.size() - base_wr), 64'd1);
    if (wr_addr.size() > base_wr)
      check("midrst.word0", {wr_addr[base_wr], wr_data[base_wr]}, {32'h0, 32'h23222120});
    check("midrst.no_done", 64'(done_cnt - base_done), 64'd0);
    snap();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    settle(4);
    check("fresh.writes", 64'(wr_addr.size() - base_wr), 64'd1);
    if (wr_addr.size() > base_wr)
      check("fresh.word", {wr_addr[base_wr], wr_data[base_wr]}, {32'h0, 32'hDDCCBBAA});
    check_timing("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
